// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//   Initiator side of the byte-addressed RAM MV/MOC handshake. Accepts one
//   1/2/4/8-byte big-endian access, presents it to the RAM, waits for moc
//   (bounded by TIMEOUT_CYCLES), then reports done/err/err_code and
//   right-justified, zero-extended read data.
//   Optional build macro: ALIGN_CHECK_EN rejects accesses whose address is
//   not a multiple of the access size (err_code 11). Without it, unaligned
//   accesses proceed normally.
module mem_req_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [63:0]       rdata,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [1:0]        mem_type,
  output logic [63:0]       mem_wdata,
  output logic              mem_enable,
  output logic              mem_mv,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_moc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ALIGN   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_DONE,
    ST_RELEASE
  } state_t;

  state_t state_reg, state_next;

  // Latched request and status
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic [63:0]       wdata_reg;
  logic              bypass_reg;   // access rejected up front, RAM never touched
  logic              err_reg;
  logic [1:0]        err_code_reg;
  logic [63:0]       rdata_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Request decode (evaluated on the incoming request at acceptance)
  logic              accept;
  logic [3:0]        req_nbytes;
  logic [ADDR_W:0]   req_end_addr;
  logic              range_err;
  logic              align_err;
  logic              reject;
  logic [1:0]        reject_code;

  assign accept       = (state_reg == ST_IDLE) && req;
  assign req_nbytes   = 4'd1 << req_size;
  // One extra bit so an access running past the top of memory is caught
  // instead of wrapping to address 0.
  assign req_end_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_nbytes) - (ADDR_W+1)'(1);
  assign range_err    = req_end_addr > (ADDR_W+1)'(2**ADDR_W - 1);

`ifdef ALIGN_CHECK_EN
  logic [ADDR_W-1:0] align_mask;
  assign align_mask = ADDR_W'(req_nbytes) - ADDR_W'(1);
  assign align_err  = |(req_addr & align_mask);
`else
  assign align_err  = 1'b0;
`endif

  // Range check takes priority over alignment
  assign reject      = range_err || align_err;
  assign reject_code = range_err ? ERR_RANGE : (align_err ? ERR_ALIGN : ERR_NONE);

  // Strobe counter: the edge on which it would reach TIMEOUT_CYCLES aborts,
  // unless moc is seen on that same edge.
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  assign cnt_inc     = cnt_reg + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Read data keeps only the bytes actually transferred
  logic [3:0]  keep_nbytes;
  logic [63:0] rdata_mask;
  assign keep_nbytes = 4'd1 << size_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rmask
      assign rdata_mask[8*gi +: 8] = {8{(4'(gi) < keep_nbytes)}};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (req) state_next = reject ? ST_DONE : ST_SETUP;
      ST_SETUP:   state_next = ST_STROBE;
      ST_STROBE:  if (mem_moc || timeout_hit) state_next = ST_DONE;
      ST_DONE:    state_next = ST_RELEASE;
      ST_RELEASE: if (!mem_moc) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem_enable = 1'b0;
    mem_mv     = 1'b0;
    case (state_reg)
      ST_SETUP:   begin busy = 1'b1; mem_enable = 1'b1; end
      ST_STROBE:  begin busy = 1'b1; mem_enable = 1'b1; mem_mv = 1'b1; end
      ST_DONE:    begin busy = 1'b1; done = 1'b1; mem_enable = !bypass_reg; end
      ST_RELEASE: busy = 1'b1;
      default:    ;
    endcase
  end

  // Request capture, strobe counting, read-data and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_reg       <= 1'b0;
      addr_reg     <= '0;
      size_reg     <= 2'b00;
      wdata_reg    <= '0;
      bypass_reg   <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
      rdata_reg    <= '0;
      cnt_reg      <= '0;
    end else begin
      if (accept) begin
        rw_reg       <= req_rw;
        addr_reg     <= req_addr;
        size_reg     <= req_size;
        wdata_reg    <= req_wdata;
        bypass_reg   <= reject;
        err_reg      <= reject;
        err_code_reg <= reject_code;
        cnt_reg      <= '0;
      end
      if (state_reg == ST_STROBE) begin
        cnt_reg <= cnt_inc;
        if (mem_moc) begin
          if (rw_reg) rdata_reg <= mem_rdata & rdata_mask;
        end else if (timeout_hit) begin
          err_reg      <= 1'b1;
          err_code_reg <= ERR_TIMEOUT;
          rdata_reg    <= '0;
        end
      end
    end
  end

  assign rdata     = rdata_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign mem_addr  = addr_reg;
  assign mem_rw    = rw_reg;
  assign mem_type  = size_reg;
  assign mem_wdata = wdata_reg;

endmodule
